fft_frame_sched: RTL and testbench

- Frame sequencer and RAM-port arbiter around the 128-point in-place radix-2 FFT core and its shared 4*DATA_WIDTH-wide sample RAM.
- Loads one frame of real samples into RAM in bit-reversed order, then pulses the core's start and hands it the RAM ports.
- On fft_done, streams the 128 complex bins out in natural order over a valid/ready interface.
- Sits between the ADC sample path and the PicoRV32 peripheral readback logic.

---
 rtl/fft_frame_sched_if.sv | 25 ++
 rtl/fft_frame_sched.sv | 200 ++++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_sched_if.sv
// Stream bundle for fft_frame_sched: the sample input stream (s_*) and the
// FFT-bin output stream (m_*). The slave modport is the scheduler's view;
// the master modport is the view of whatever feeds samples and takes bins.
interface fft_frame_sched_if #(
   parameter int DATA_WIDTH = 16
) ();
   logic                    s_valid;
   logic [DATA_WIDTH-1:0]   s_data;
   logic                    s_ready;
   logic                    m_valid;
   logic                    m_ready;
   logic [4*DATA_WIDTH-1:0] m_data;
   logic [6:0]              m_index;
   logic                    m_last;

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_index, m_last
   );

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_index, m_last
   );
endinterface

// File: rtl/fft_frame_sched.sv
// Frame sequencer and RAM-port arbiter for a 128-point in-place radix-2 FFT.
// LOAD writes real samples to RAM in bit-reversed order, START pulses the
// core, RUN hands the RAM ports to the core, DRAIN streams bins 0..127 out
// through a 2-entry FIFO. Optional RUN watchdog: define FFT_SCHED_TIMEOUT_EN.
module fft_frame_sched #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_auto,
   input  logic                    go,
   fft_frame_sched_if.slave        bus,
   output logic                    fft_start,
   input  logic                    fft_done,
   input  logic                    fft_wen,
   input  logic                    fft_ren,
   input  logic [ADDR_WIDTH-1:0]   fft_waddr,
   input  logic [ADDR_WIDTH-1:0]   fft_raddr,
   input  logic [4*DATA_WIDTH-1:0] fft_wdata,
   output logic                    ram_wen,
   output logic                    ram_ren,
   output logic [ADDR_WIDTH-1:0]   ram_waddr,
   output logic [ADDR_WIDTH-1:0]   ram_raddr,
   output logic [4*DATA_WIDTH-1:0] ram_wdata,
   input  logic [4*DATA_WIDTH-1:0] ram_rdata,
   output logic                    busy,
   output logic                    err_timeout
);
   localparam int W    = 4 * DATA_WIDTH;
   localparam int HALF = 2 * DATA_WIDTH;

   typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN} state_t;

   state_t                state;
   logic [6:0]            ld_cnt;
   logic                  wen_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [W-1:0]          wdata_q;
   logic [7:0]            rd_cnt;
   logic                  rdv_q;
   logic [W-1:0]          fifo_mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            occ;
   logic [6:0]            out_idx;
   logic                  pop;
   logic                  issue;
   logic [2:0]            pending;

   function automatic logic [6:0] bitrev7(input logic [6:0] x);
      for (int i = 0; i < 7; i++) bitrev7[i] = x[6-i];
   endfunction

   assign busy        = (state != IDLE);
   assign bus.s_ready = (state == LOAD);
   assign bus.m_valid = (occ != 2'd0);
   assign bus.m_data  = fifo_mem[rd_ptr];
   assign bus.m_index = out_idx;
   assign bus.m_last  = bus.m_valid && (out_idx == 7'd127);
   assign pop         = bus.m_valid && bus.m_ready;

   // Reads still owed to the FIFO after this cycle: entries kept plus the one landing now.
   assign pending = 3'(occ) + 3'(rdv_q) - 3'(pop);
   assign issue   = (state == DRAIN) && !rd_cnt[7] && (pending < 3'd2);

`ifdef FFT_SCHED_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        err_q;
   assign err_timeout = err_q;
`else
   // Tied low; the comparison is constant-false for any legal limit.
   assign err_timeout = (TIMEOUT_CYC < 0);
`endif

   // Frame sequencer: state, load-side write register, start pulse, watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ld_cnt    <= '0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         fft_start <= 1'b0;
`ifdef FFT_SCHED_TIMEOUT_EN
         tmo_cnt   <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         // NOTE: state is updated with <= so every branch below reads the
         // pre-edge values; a blocking '=' here would create order-dependent races.
         fft_start <= 1'b0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
`ifdef FFT_SCHED_TIMEOUT_EN
         err_q     <= 1'b0;
         tmo_cnt   <= (state == RUN) ? tmo_cnt + 16'd1 : 16'd0;
`endif
         case (state)
            IDLE: begin
               if (go) begin
                  state  <= LOAD;
                  ld_cnt <= '0;
               end
            end
            LOAD: begin
               if (bus.s_valid) begin
                  wen_q   <= 1'b1;
                  waddr_q <= ADDR_WIDTH'(bitrev7(ld_cnt));
                  wdata_q <= {{HALF{1'b0}},
                              {(HALF-DATA_WIDTH){bus.s_data[DATA_WIDTH-1]}}, bus.s_data};
                  ld_cnt  <= ld_cnt + 7'd1;
                  if (ld_cnt == 7'd127) begin
                     state     <= START;
                     fft_start <= 1'b1;
                  end
               end
            end
            START: state <= RUN;
            RUN: begin
               if (fft_done) begin
                  state <= DRAIN;
`ifdef FFT_SCHED_TIMEOUT_EN
               end else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
                  state <= IDLE;
                  err_q <= 1'b1;
`endif
               end
            end
            DRAIN: begin
               if (pop && out_idx == 7'd127) begin
                  state  <= cfg_auto ? LOAD : IDLE;
                  ld_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Drain datapath: read address counter, read-latency tracker, 2-entry output FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt  <= '0;
         rdv_q   <= 1'b0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         occ     <= '0;
         out_idx <= '0;
         // NOTE: the two FIFO words are cleared so m_data reads 0 out of reset;
         // a deep RAM would normally be left unreset.
         for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      end else begin
         rdv_q <= issue;
         if (state != DRAIN) begin
            rd_cnt  <= '0;
            out_idx <= '0;
         end else begin
            if (issue) rd_cnt  <= rd_cnt + 8'd1;
            if (pop)   out_idx <= out_idx + 7'd1;
         end
         if (rdv_q) begin
            fifo_mem[wr_ptr] <= ram_rdata;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= occ + 2'(rdv_q) - 2'(pop);
      end
   end

   // RAM port arbiter: core owns the ports in RUN, the sequencer otherwise.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      ram_wen   = 1'b0;
      ram_ren   = 1'b0;
      ram_waddr = '0;
      ram_raddr = '0;
      ram_wdata = '0;
      case (state)
         RUN: begin
            ram_wen   = fft_wen;
            ram_ren   = fft_ren;
            ram_waddr = fft_waddr;
            ram_raddr = fft_raddr;
            ram_wdata = fft_wdata;
         end
         DRAIN: begin
            ram_ren   = issue;
            ram_raddr = ADDR_WIDTH'(rd_cnt[6:0]);
         end
         default: begin
            ram_wen   = wen_q;
            ram_waddr = waddr_q;
            ram_wdata = wdata_q;
         end
      endcase
   end
endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched with a behavioural 256x64 RAM model.
module tb_fft_frame_sched;
   logic        clk = 1'b0;
   logic        rst, cfg_auto, go;
   logic        fft_start, fft_done, fft_wen, fft_ren;
   logic [7:0]  fft_waddr, fft_raddr, ram_waddr, ram_raddr;
   logic [63:0] fft_wdata, ram_wdata, ram_rdata;
   logic        ram_wen, ram_ren, busy, err_timeout;
   logic [63:0] mem [256];
   int          checks = 0;
   int          failures = 0;
   int          start_cnt = 0;
   int          err_cnt = 0;

   fft_frame_sched_if #(.DATA_WIDTH(16)) bus ();

   fft_frame_sched #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .TIMEOUT_CYC(4096)) dut (
      .clk(clk), .rst(rst), .cfg_auto(cfg_auto), .go(go), .bus(bus),
      .fft_start(fft_start), .fft_done(fft_done), .fft_wen(fft_wen), .fft_ren(fft_ren),
      .fft_waddr(fft_waddr), .fft_raddr(fft_raddr), .fft_wdata(fft_wdata),
      .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Synchronous RAM, read data one cycle after ram_ren.
   always @(posedge clk) begin
      if (ram_wen) mem[ram_waddr] <= ram_wdata;
      if (ram_ren) ram_rdata <= mem[ram_raddr];
   end

   // Pulse monitors, sampled mid-cycle.
   always @(negedge clk) begin
      if (fft_start)   start_cnt++;
      if (err_timeout) err_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] rev7(input logic [6:0] x);
      logic [6:0] r;
      for (int i = 0; i < 7; i++) r[i] = x[6-i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int          hs, bad, t, j;
      logic [63:0] exp_word;
      logic [31:0] re;

      rst = 1'b1; cfg_auto = 1'b0; go = 1'b0; fft_done = 1'b0;
      fft_wen = 1'b0; fft_ren = 1'b0; fft_waddr = '0; fft_raddr = '0; fft_wdata = '0;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_ctrl", {bus.s_ready, busy, fft_start, ram_wen, ram_ren, ram_waddr,
                           ram_raddr, bus.m_valid, bus.m_index, bus.m_last, err_timeout}, '0);
      check("reset_mdata", bus.m_data, '0);
      rst = 1'b0;
      @(negedge clk);

      // Stray fft_done and s_valid while IDLE have no effect.
      fft_done = 1'b1; bus.s_valid = 1'b1;
      check("idle_s_ready", bus.s_ready, 1'b0);
      @(negedge clk);
      fft_done = 1'b0; bus.s_valid = 1'b0;
      check("idle_ignores_done", {busy, bus.m_valid}, 2'b00);

      // Frame 1: samples k = 0..127, no gaps.
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("load_entry", {busy, bus.s_ready}, 2'b11);
      for (int k = 0; k < 128; k++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(k);
         @(negedge clk);
         if (k == 1)   check("waddr_k1", {ram_wen, ram_waddr}, {1'b1, 8'h40});
         if (k == 3)   check("waddr_k3", {ram_wen, ram_waddr}, {1'b1, 8'h60});
         if (k == 126) check("no_early_start", fft_start, 1'b0);
         if (k == 127) begin
            check("start_pulse", fft_start, 1'b1);
            check("last_write", {ram_wen, ram_waddr, ram_wdata}, {1'b1, 8'h7F, 64'd127});
            check("start_s_ready", bus.s_ready, 1'b0);
         end
      end
      @(negedge clk);   // RUN
      check("start_once", 64'(start_cnt), 64'd1);
      bad = 0;
      for (int k = 0; k < 128; k++) if (mem[{1'b0, rev7(7'(k))}] !== 64'(k)) bad++;
      check("load_bitrev_all", 64'(bad), 64'd0);
      check("run_s_ready", bus.s_ready, 1'b0);

      // RUN: core drives the RAM ports combinationally.
      fft_waddr = 8'h15; fft_wen = 1'b1; fft_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
      fft_raddr = 8'h22; fft_ren = 1'b1;
      #1;
      check("run_wr_pass", {ram_wen, ram_waddr, ram_wdata}, {1'b1, 8'h15, 64'hAAAA_BBBB_CCCC_DDDD});
      check("run_rd_pass", {ram_ren, ram_raddr}, {1'b1, 8'h22});
      bus.s_valid = 1'b0; fft_ren = 1'b0;
      go = 1'b1;   // ignored outside IDLE
      for (int a = 0; a < 128; a++) begin
         fft_waddr = 8'(a); fft_wdata = 64'(a);
         @(negedge clk);
         go = 1'b0;
      end
      fft_wen = 1'b0;
      check("run_go_ignored", busy, 1'b1);

      // Drain with m_ready held high.
      bus.m_ready = 1'b1;
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
      check("drain_c0_valid", bus.m_valid, 1'b0);
      @(negedge clk);
      check("drain_c1_valid", bus.m_valid, 1'b0);
      @(negedge clk);
      check("drain_c2_first", {bus.m_valid, bus.m_index}, {1'b1, 7'd0});
      hs = 0; bad = 0; t = 0;
      while (hs < 128 && t < 1000) begin
         if (bus.m_valid && bus.m_ready) begin
            if (bus.m_index !== 7'(hs) || bus.m_data !== 64'(hs)) bad++;
            if (bus.m_last !== (hs == 127)) bad++;
            hs++;
         end
         @(negedge clk);
         t++;
      end
      check("drain1_count", 64'(hs), 64'd128);
      check("drain1_order", 64'(bad), 64'd0);
      check("drain1_rate", 64'(t), 64'd128);
      check("drain1_busy_fall", busy, 1'b0);

      // Frame 2: negative samples, auto-restart, random backpressure.
      cfg_auto = 1'b1;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int k = 0; k < 128; k++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(-(k + 1));
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      repeat (3) @(negedge clk);
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
      hs = 0; bad = 0; t = 0;
      while (hs < 128 && t < 2000) begin
         bus.m_ready = ($urandom_range(0, 9) >= 3);
         if (bus.m_valid && bus.m_ready) begin
            j  = int'(rev7(7'(hs)));
            re = 32'(-(j + 1));
            exp_word = {32'h0, re};
            if (bus.m_index !== 7'(hs) || bus.m_data !== exp_word) bad++;
            if (bus.m_last !== (hs == 127)) bad++;
            hs++;
         end
         @(negedge clk);
         t++;
      end
      check("drain2_count", 64'(hs), 64'd128);
      check("drain2_order", 64'(bad), 64'd0);
      check("auto_reload", {busy, bus.s_ready}, 2'b11);
      bus.m_ready = 1'b0;

      // Reset in the middle of the auto-started LOAD.
      for (int k = 0; k < 60; k++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(k);
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      check("midload_rst_ctrl", {bus.s_ready, busy, fft_start, ram_wen, ram_ren, ram_waddr,
                                 ram_raddr, bus.m_valid, bus.m_index, bus.m_last, err_timeout}, '0);
      check("midload_rst_data", {ram_wdata, bus.m_data}, '0);
      @(negedge clk);
      rst = 1'b0; bus.s_valid = 1'b0; cfg_auto = 1'b0;
      @(negedge clk);
      check("post_rst_idle", busy, 1'b0);

`ifdef FFT_SCHED_TIMEOUT_EN
      // Watchdog: withhold fft_done.
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int k = 0; k < 128; k++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(k);
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      @(negedge clk);   // first RUN cycle
      t = 0;
      while (!err_timeout && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("timeout_delay", 64'(t), 64'd4096);
      check("timeout_idle", busy, 1'b0);
      @(negedge clk);
      check("timeout_single", 64'(err_cnt), 64'd1);
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
      check("late_done_ignored", {busy, bus.m_valid}, 2'b00);
`else
      check("no_timeout_pulse", 64'(err_cnt), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
